// File: rtl/button_debounce.sv
// button_debounce
// Turns the raw push-button pad into clean, clk-synchronous control signals:
// a debounced level, one-cycle press/release strobes, a press-toggled latch
// suitable for driving an LED directly, and a busy flag while a candidate
// change is being qualified.
//
// The pad is first brought into the clk domain by a two-flop synchroniser.
// A four-state machine then qualifies every change. The synchronised sample
// must disagree with the current debounced level on DEBOUNCE_CYCLES
// consecutive edges before that level is allowed to flip.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int CNT_WIDTH       = 18,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic toggle,
  output logic busy
);

  // Terminal count. When the counter holds this value and the sample still
  // disagrees, the debounced level flips on that edge.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  // RELEASED / HELD are the two settled levels.
  // QUAL_PRESS / QUAL_RELEASE are counting a candidate change.
  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    QUAL_PRESS   = 2'd1,
    HELD         = 2'd2,
    QUAL_RELEASE = 2'd3
  } state_t;

  // Pad level normalised so that 1 always means "pressed".
  logic raw;

  // sync_reg[0] is the only flop that looks at the asynchronous pad.
  // sync_reg[1] is the first stage safe to use in logic.
  logic [1:0] sync_reg;
  logic       sample;

  state_t               state_reg;
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic                 pressed_reg;
  logic                 press_pulse_reg;
  logic                 release_pulse_reg;
  logic                 toggle_reg;
  logic                 busy_reg;

  assign raw    = button ^ ACTIVE_LOW;
  assign sample = sync_reg[1];

  // Two-flop synchroniser. It resets to the released level so that a button
  // held through reset is qualified again as a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], raw};
    end
  end

  // Qualification FSM with counter. All outputs are registered, and the
  // strobes and toggle update on the same edge that the level flips.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= RELEASED;
      cnt_reg           <= '0;
      pressed_reg       <= 1'b0;
      press_pulse_reg   <= 1'b0;
      release_pulse_reg <= 1'b0;
      toggle_reg        <= 1'b0;
      busy_reg          <= 1'b0;
    end else begin
      // Strobes default low; they are raised only on the flip edge.
      press_pulse_reg   <= 1'b0;
      release_pulse_reg <= 1'b0;

      case (state_reg)
        RELEASED: begin
          if (sample) begin
            // First disagreeing sample: the count goes 0 -> 1.
            state_reg <= QUAL_PRESS;
            cnt_reg   <= CNT_WIDTH'(1);
            busy_reg  <= 1'b1;
          end else begin
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
          end
        end

        QUAL_PRESS: begin
          if (!sample) begin
            // A bounce back to the settled level abandons the candidate.
            state_reg <= RELEASED;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg       <= HELD;
            cnt_reg         <= '0;
            busy_reg        <= 1'b0;
            pressed_reg     <= 1'b1;
            press_pulse_reg <= 1'b1;
            toggle_reg      <= ~toggle_reg;
          end else begin
            cnt_reg  <= cnt_reg + CNT_WIDTH'(1);
            busy_reg <= 1'b1;
          end
        end

        HELD: begin
          if (!sample) begin
            state_reg <= QUAL_RELEASE;
            cnt_reg   <= CNT_WIDTH'(1);
            busy_reg  <= 1'b1;
          end else begin
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
          end
        end

        QUAL_RELEASE: begin
          if (sample) begin
            state_reg <= HELD;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
          end else if (cnt_reg == CNT_LAST) begin
            // toggle is left alone: it only follows presses.
            state_reg         <= RELEASED;
            cnt_reg           <= '0;
            busy_reg          <= 1'b0;
            pressed_reg       <= 1'b0;
            release_pulse_reg <= 1'b1;
          end else begin
            cnt_reg  <= cnt_reg + CNT_WIDTH'(1);
            busy_reg <= 1'b1;
          end
        end

        default: begin
          state_reg <= RELEASED;
          cnt_reg   <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign pressed       = pressed_reg;
  assign press_pulse   = press_pulse_reg;
  assign release_pulse = release_pulse_reg;
  assign toggle        = toggle_reg;
  assign busy          = busy_reg;

endmodule
